// File: rtl/byte_demux2_pkg.sv
// byte_demux2_pkg -- shared constants and types for the 1-to-2 byte demux.
//
//   WIDTH    default data width of the routed stream
//   STATS_W  width of the optional per-channel delivery counters
//   ch_e     channel selector encoding used to decode in_sel
package byte_demux2_pkg;

  localparam int WIDTH   = 8;
  localparam int STATS_W = 16;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

endpackage : byte_demux2_pkg

// File: rtl/byte_demux2_sync_fifo.sv
// sync_fifo -- single-clock FIFO with registered storage, one per demux channel.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; empties the FIFO and zeroes storage
//   push       write push_data this cycle (ignored while full)
//   push_data  WIDTH-bit byte to store
//   pop        remove the head entry this cycle (ignored while empty)
//   full       no free entry; registered-pointer comparison only
//   empty      no stored entry; registered-pointer comparison only
//   head_data  oldest stored entry, muxed straight from the storage registers
//
// Pointers carry one extra MSB so that DEPTH entries can be told apart from
// zero entries: equal pointers mean empty, pointers differing only in the MSB
// mean full. Both wrap naturally modulo 2*DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      wr_ptr_next;
  logic [AW:0]      rd_ptr_reg;
  logic [AW:0]      rd_ptr_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A push is refused while full even if a pop happens in the same cycle,
  // so a full channel never accepts a push-through.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_en) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage is cleared on reset so the head byte reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push_en) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule : sync_fifo

// File: rtl/byte_demux2.sv
// byte_demux2 -- buffered 1-to-2 byte demultiplexer with valid/ready handshakes.
//
// Each input byte is steered by in_sel into one of two independent FIFOs.
// The producer only stalls when the addressed channel is full; the other
// channel never blocks it.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        producer handshake; in_ready = channel in_sel not full
//   in_data, in_sel          byte to route and its target channel (0 or 1)
//   out0_valid/out0_ready    channel 0 consumer handshake
//   out0_data                channel 0 head byte
//   out1_valid/out1_ready    channel 1 consumer handshake
//   out1_data                channel 1 head byte
//   cnt0, cnt1               per-channel delivered-byte counters (16-bit,
//                            wrapping); only with BYTE_DEMUX2_STATS_EN defined
//
// Optional feature macro: BYTE_DEMUX2_STATS_EN
module byte_demux2 #(
  parameter int WIDTH = byte_demux2_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef BYTE_DEMUX2_STATS_EN
  ,
  output logic [byte_demux2_pkg::STATS_W-1:0] cnt0,
  output logic [byte_demux2_pkg::STATS_W-1:0] cnt1
`endif
);

  import byte_demux2_pkg::*;

  ch_e              sel_ch;
  logic [1:0]       sel_onehot;
  logic [1:0]       full_w;
  logic [1:0]       empty_w;
  logic [1:0]       push_w;
  logic [1:0]       pop_w;
  logic [1:0]       out_ready_w;
  logic [WIDTH-1:0] head_w [2];

  assign sel_ch = ch_e'(in_sel);

  always_comb begin
    sel_onehot = 2'b00;
    case (sel_ch)
      CH0:     sel_onehot = 2'b01;
      CH1:     sel_onehot = 2'b10;
      default: sel_onehot = 2'b00;
    endcase
  end

  // Ready looks only at the selected channel's registered full flag, so there
  // is no combinational path from any consumer ready to in_ready.
  assign in_ready    = |(sel_onehot & ~full_w);
  assign out_ready_w = {out1_ready, out0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      assign push_w[gi] = in_valid & sel_onehot[gi] & ~full_w[gi];
      assign pop_w[gi]  = out_ready_w[gi] & ~empty_w[gi];

      sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_w[gi]),
        .push_data (in_data),
        .pop       (pop_w[gi]),
        .full      (full_w[gi]),
        .empty     (empty_w[gi]),
        .head_data (head_w[gi])
      );
    end
  endgenerate

  assign out0_valid = ~empty_w[0];
  assign out1_valid = ~empty_w[1];
  assign out0_data  = head_w[0];
  assign out1_data  = head_w[1];

`ifdef BYTE_DEMUX2_STATS_EN
  logic [STATS_W-1:0] cnt_reg  [2];
  logic [STATS_W-1:0] cnt_next [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // Counts completed pops; the 16-bit add wraps 0xFFFF -> 0x0000.
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        if (pop_w[gi]) begin
          cnt_next[gi] = cnt_reg[gi] + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  assign cnt0 = cnt_reg[0];
  assign cnt1 = cnt_reg[1];
`endif

endmodule : byte_demux2

// File: tb/tb_byte_demux2.sv
// tb_byte_demux2 -- scoreboard bench for byte_demux2 (WIDTH = 8, DEPTH = 2).
// Stimulus pushes hand-chosen expected bytes into per-channel queues; an
// independent monitor pops and compares whenever a channel delivers a byte.
module tb_byte_demux2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_sel;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_data;
`ifdef BYTE_DEMUX2_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  byte_demux2 #(
    .WIDTH (8),
    .DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef BYTE_DEMUX2_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, where the inputs the next rising
  // edge will see are already stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (exp_q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ch0_unexpected: got 0x%0h, expected no byte", out0_data);
        end else begin
          check("ch0_data", {24'd0, out0_data}, {24'd0, exp_q0.pop_front()});
        end
      end
      if (out1_valid && out1_ready) begin
        if (exp_q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ch1_unexpected: got 0x%0h, expected no byte", out1_data);
        end else begin
          check("ch1_data", {24'd0, out1_data}, {24'd0, exp_q1.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for one cycle; exp_rdy is the hand-computed in_ready.
  task automatic send(input logic s, input logic [7:0] d, input logic exp_rdy, input string name);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    @(negedge clk);
    check(name, {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) begin
      if (s) exp_q1.push_back(d);
      else   exp_q0.push_back(d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, exp_q0.size() + exp_q1.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic done;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = 8'h00;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset then idle
    check("rst_out0_valid", {31'd0, out0_valid}, 0);
    check("rst_out1_valid", {31'd0, out1_valid}, 0);
    check("rst_out0_data", {24'd0, out0_data}, 0);
    check("rst_out1_data", {24'd0, out1_data}, 0);
    in_sel = 1'b0;
    #1;
    check("rst_ready_sel0", {31'd0, in_ready}, 1);
    in_sel = 1'b1;
    #1;
    check("rst_ready_sel1", {31'd0, in_ready}, 1);
`ifdef BYTE_DEMUX2_STATS_EN
    check("rst_cnt0", {16'd0, cnt0}, 0);
    check("rst_cnt1", {16'd0, cnt1}, 0);
`endif
    tick();

    // Alternating routing, both consumers ready
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 8'h11, 1'b1, "alt_rdy_11");
    check("alt_valid0_after_11", {31'd0, out0_valid}, 1);
    send(1'b1, 8'h22, 1'b1, "alt_rdy_22");
    check("alt_valid1_after_22", {31'd0, out1_valid}, 1);
    send(1'b0, 8'h33, 1'b1, "alt_rdy_33");
    check("alt_valid0_after_33", {31'd0, out0_valid}, 1);
    wait_drain("alt_drain");
    check("alt_idle_valid0", {31'd0, out0_valid}, 0);

    // Backpressure: ch0 fills at two entries, ch1 still accepts
    out0_ready = 1'b0;
    send(1'b0, 8'hA0, 1'b1, "bp_rdy_A0");
    send(1'b0, 8'hA1, 1'b1, "bp_rdy_A1");
    send(1'b0, 8'hA2, 1'b0, "bp_full_A2");
    send(1'b1, 8'hB0, 1'b1, "bp_other_B0");
    check("bp_valid0_held", {31'd0, out0_valid}, 1);
    check("bp_head0_held", {24'd0, out0_data}, 32'hA0);

    // Full + pop in the same cycle: no push-through, accepted next cycle
    out0_ready = 1'b1;
    send(1'b0, 8'hA2, 1'b0, "fullpop_no_push");
    send(1'b0, 8'hA2, 1'b1, "fullpop_next_push");
    wait_drain("fullpop_drain");

    // Reset so the wrap test starts with zeroed counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Wrap-around through ch1 with random consumer stalls
    out0_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = 8'(i);
      n        = 0;
      done     = 1'b0;
      while (!done && n < 200) begin
        out1_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (in_ready) begin
          exp_q1.push_back(8'(i));
          done = 1'b1;
        end
        tick();
        n++;
      end
      in_valid = 1'b0;
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL wrap_accept: got no accept for byte %0d, expected accept", i);
      end
    end
    out1_ready = 1'b1;
    wait_drain("wrap_drain");
`ifdef BYTE_DEMUX2_STATS_EN
    check("wrap_cnt1", {16'd0, cnt1}, 10);
    check("wrap_cnt0", {16'd0, cnt0}, 0);
`endif

    // Reset mid-operation with a concurrent push
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 8'hC0, 1'b1, "mid_rdy_C0");
    send(1'b1, 8'hD0, 1'b1, "mid_rdy_D0");
    check("mid_valid0_before", {31'd0, out0_valid}, 1);
    check("mid_valid1_before", {31'd0, out1_valid}, 1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 8'hEE;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    check("mid_valid0_after", {31'd0, out0_valid}, 0);
    check("mid_valid1_after", {31'd0, out1_valid}, 0);
    check("mid_data0_after", {24'd0, out0_data}, 0);
    check("mid_data1_after", {24'd0, out1_data}, 0);
`ifdef BYTE_DEMUX2_STATS_EN
    check("mid_cnt0", {16'd0, cnt0}, 0);
    check("mid_cnt1", {16'd0, cnt1}, 0);
`endif
    // The only byte delivered after reset must be the fresh one
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(1'b0, 8'h5A, 1'b1, "post_rst_rdy_5A");
    wait_drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_byte_demux2
